// File: rtl/cluster_unpacker.sv
// cluster_unpacker: rebuilds the 1536-bit s-bit map from eight packed cluster
// words ({cnt[2:0], adr[10:0]}). One cluster set is accepted per transaction,
// slots are expanded serially one per clock, and the rebuilt map is published
// with a one-cycle valid strobe.
//
// Ports:
//   clock4x          single clock
//   global_reset     synchronous, active-high reset
//   cluster0..7      cluster words, cluster0 expanded first
//   clusters_valid   cluster inputs valid this cycle
//   clusters_ready   block can accept a cluster set (IDLE only)
//   sbits            rebuilt s-bit map, bit n = strip n
//   sbits_valid      one-cycle strobe, sbits updated in the same cycle
//   num_clusters     count of non-null, in-range clusters in last set
//   err_count        saturating count of malformed clusters since reset
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a new cluster set
// EXPAND  | OR one slot per cycle into the accumulator (always 8 cycles)
// PUBLISH | copy accumulator and tally to the outputs, pulse sbits_valid
module cluster_unpacker #(
  parameter int          NUM_STRIPS = 1536,
  parameter logic [10:0] NULL_ADR   = 11'h7FF,
  parameter int          ERR_BITS   = 8
) (
  input  logic                  clock4x,
  input  logic                  global_reset,
  input  logic [13:0]           cluster0,
  input  logic [13:0]           cluster1,
  input  logic [13:0]           cluster2,
  input  logic [13:0]           cluster3,
  input  logic [13:0]           cluster4,
  input  logic [13:0]           cluster5,
  input  logic [13:0]           cluster6,
  input  logic [13:0]           cluster7,
  input  logic                  clusters_valid,
  output logic                  clusters_ready,
  output logic [NUM_STRIPS-1:0] sbits,
  output logic                  sbits_valid,
  output logic [3:0]            num_clusters,
  output logic [ERR_BITS-1:0]   err_count
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_PUBLISH} state_t;

  localparam logic [10:0] STRIP_LIMIT = 11'(NUM_STRIPS);

  state_t                state_q, state_d;
  logic [7:0][13:0]      words_q, words_d;
  logic [2:0]            slot_q, slot_d;
  logic [3:0]            tally_q, tally_d;
  logic [NUM_STRIPS-1:0] acc_q, acc_d;
  logic [NUM_STRIPS-1:0] sbits_q, sbits_d;
  logic                  sbits_valid_q, sbits_valid_d;
  logic [3:0]            num_q, num_d;
  logic [ERR_BITS-1:0]   err_q, err_d;

  logic [13:0] cur_word;
  logic [2:0]  cur_cnt;
  logic [10:0] cur_adr;

  assign cur_word = words_q[slot_q];
  assign cur_cnt  = cur_word[13:11];
  assign cur_adr  = cur_word[10:0];

  always_comb begin
    state_d       = state_q;
    words_d       = words_q;
    slot_d        = slot_q;
    tally_d       = tally_q;
    acc_d         = acc_q;
    sbits_d       = sbits_q;
    sbits_valid_d = 1'b0;
    num_d         = num_q;
    err_d         = err_q;

    case (state_q)
      S_IDLE: begin
        if (clusters_valid) begin
          words_d = {cluster7, cluster6, cluster5, cluster4,
                     cluster3, cluster2, cluster1, cluster0};
          acc_d   = '0;
          slot_d  = 3'd0;
          tally_d = 4'd0;
          state_d = S_EXPAND;
        end
      end

      S_EXPAND: begin
        if (cur_adr == NULL_ADR) begin
          // empty slot: nothing to do
        end else if (cur_adr >= STRIP_LIMIT) begin
          if (err_q != {ERR_BITS{1'b1}}) err_d = err_q + ERR_BITS'(1);
        end else begin
          tally_d = tally_q + 4'd1;
          // adr < NUM_STRIPS here, so adr+i cannot wrap 11 bits; strips past
          // the end of the map are simply dropped.
          for (int i = 0; i < 8; i++) begin
            if ((3'(i) <= cur_cnt) && ((cur_adr + 11'(i)) < STRIP_LIMIT))
              acc_d[cur_adr + 11'(i)] = 1'b1;
          end
        end
        if (slot_q == 3'd7) state_d = S_PUBLISH;
        else                slot_d  = slot_q + 3'd1;
      end

      S_PUBLISH: begin
        sbits_d       = acc_q;
        num_d         = tally_q;
        sbits_valid_d = 1'b1;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      state_q       <= S_IDLE;
      words_q       <= '0;
      slot_q        <= 3'd0;
      tally_q       <= 4'd0;
      acc_q         <= '0;
      sbits_q       <= '0;
      sbits_valid_q <= 1'b0;
      num_q         <= 4'd0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      words_q       <= words_d;
      slot_q        <= slot_d;
      tally_q       <= tally_d;
      acc_q         <= acc_d;
      sbits_q       <= sbits_d;
      sbits_valid_q <= sbits_valid_d;
      num_q         <= num_d;
      err_q         <= err_d;
    end
  end

  assign clusters_ready = (state_q == S_IDLE);
  assign sbits          = sbits_q;
  assign sbits_valid    = sbits_valid_q;
  assign num_clusters   = num_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_cluster_unpacker.sv
module tb_cluster_unpacker;

  logic             clock4x = 1'b0;
  logic             global_reset = 1'b1;
  logic [7:0][13:0] cl;
  logic             clusters_valid = 1'b0;
  logic             clusters_ready;
  logic [1535:0]    sbits;
  logic             sbits_valid;
  logic [3:0]       num_clusters;
  logic [7:0]       err_count;

  cluster_unpacker dut (
    .clock4x(clock4x), .global_reset(global_reset),
    .cluster0(cl[0]), .cluster1(cl[1]), .cluster2(cl[2]), .cluster3(cl[3]),
    .cluster4(cl[4]), .cluster5(cl[5]), .cluster6(cl[6]), .cluster7(cl[7]),
    .clusters_valid(clusters_valid), .clusters_ready(clusters_ready),
    .sbits(sbits), .sbits_valid(sbits_valid),
    .num_clusters(num_clusters), .err_count(err_count)
  );

  always #5 clock4x = ~clock4x;

  typedef struct {
    logic [1535:0] map;
    int            n;
    int            err;
    int            acc_cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   model_err = 0;

  always @(posedge clock4x) cyc <= cyc + 1;

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_map(input string nm, input logic [1535:0] act, input logic [1535:0] exp);
    int first;
    checks++;
    if (act !== exp) begin
      failures++;
      first = -1;
      for (int i = 1535; i >= 0; i--) if (act[i] !== exp[i]) first = i;
      $display("FAIL %s: got popcount %0d expected popcount %0d, lowest differing bit %0d (got %b)",
               nm, $countones(act), $countones(exp), first, act[first]);
    end
  endtask

  // Reference: each non-null in-range cluster lights strips adr..adr+cnt
  // (clipped at 1536); out-of-range addresses bump a saturating error count.
  task automatic predict(input logic [7:0][13:0] w, output exp_t e);
    int adr, cnt;
    e.map = '0;
    e.n   = 0;
    for (int k = 0; k < 8; k++) begin
      adr = int'(w[k][10:0]);
      cnt = int'(w[k][13:11]);
      if (adr == 2047) continue;
      if (adr >= 1536) begin
        if (model_err < 255) model_err++;
        continue;
      end
      for (int s = adr; s <= adr + cnt; s++) if (s < 1536) e.map[s] = 1'b1;
      e.n++;
    end
    e.err = model_err;
    e.acc_cyc = 0;
  endtask

  task automatic push_expect(input logic [7:0][13:0] w);
    exp_t e;
    predict(w, e);
    e.acc_cyc = cyc + 1;
    sbq.push_back(e);
  endtask

  // Monitor: every sbits_valid pops one expectation.
  always @(negedge clock4x) begin
    exp_t e;
    if (!global_reset && sbits_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: sbits_valid=1 with no set pending (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk_int("latency", cyc - e.acc_cyc, 9);
        chk_map("sbits", sbits, e.map);
        chk_int("num_clusters", int'(num_clusters), e.n);
        chk_int("err_count", int'(err_count), e.err);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0][13:0] w);
    int t;
    cl = w;
    clusters_valid = 1'b1;
    t = 0;
    while (!clusters_ready && t < 50) begin
      @(negedge clock4x);
      t++;
    end
    if (!clusters_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: clusters_ready got 0 expected 1 within 50 cycles");
    end else begin
      push_expect(w);
    end
    @(negedge clock4x);
    clusters_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clock4x);
      t++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending sets got %0d expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clock4x);
  endtask

  function automatic logic [13:0] rand_word();
    int         sel;
    logic [10:0] a;
    logic [2:0]  c;
    sel = $urandom_range(0, 9);
    c = 3'($urandom_range(0, 7));
    if (sel < 3)       a = 11'h7FF;
    else if (sel == 3) a = 11'($urandom_range(1536, 2046));
    else if (sel == 4) a = 11'($urandom_range(1528, 1535));
    else if (sel == 5) a = 11'(64 * $urandom_range(0, 23) + $urandom_range(56, 63));
    else               a = 11'($urandom_range(0, 1535));
    return {c, a};
  endfunction

  logic [7:0][13:0] w;
  logic [1535:0]    m;
  int               ready_cycs[$];

  initial begin
    for (int k = 0; k < 8; k++) cl[k] = 14'h07FF;
    repeat (3) @(negedge clock4x);
    chk_int("reset_ready", int'(clusters_ready), 1);
    chk_int("reset_valid", int'(sbits_valid), 0);
    global_reset = 1'b0;
    @(negedge clock4x);
    chk_map("reset_sbits", sbits, '0);
    chk_int("reset_num", int'(num_clusters), 0);
    chk_int("reset_err", int'(err_count), 0);
    chk_int("reset_ready_after", int'(clusters_ready), 1);

    // single cluster
    for (int k = 0; k < 8; k++) w[k] = 14'h07FF;
    w[0] = {3'd1, 11'd2};
    send(w);
    drain();
    m = '0; m[2] = 1'b1; m[3] = 1'b1;
    chk_map("single_direct", sbits, m);
    chk_int("single_num", int'(num_clusters), 1);
    chk_int("single_err", int'(err_count), 0);

    // packer pattern of 8 pairs
    for (int k = 0; k < 8; k++) w[k] = {3'd1, 11'(192 * k)};
    send(w);
    drain();
    m = '0;
    for (int k = 0; k < 8; k++) begin m[192*k] = 1'b1; m[192*k+1] = 1'b1; end
    chk_map("pairs_direct", sbits, m);
    chk_int("pairs_num", int'(num_clusters), 8);

    // boundaries
    for (int k = 0; k < 8; k++) w[k] = 14'h07FF;
    w[0] = {3'd7, 11'd1532};
    w[1] = {3'd3, 11'd62};
    w[2] = {3'd0, 11'd1536};
    w[3] = {3'd0, 11'h7FF};
    send(w);
    drain();
    m = '0;
    for (int s = 1532; s < 1536; s++) m[s] = 1'b1;
    for (int s = 62; s < 66; s++) m[s] = 1'b1;
    chk_map("bound_direct", sbits, m);
    chk_int("bound_num", int'(num_clusters), 2);
    chk_int("bound_err", int'(err_count), 1);

    // overlap
    for (int k = 0; k < 8; k++) w[k] = 14'h07FF;
    w[0] = {3'd2, 11'd10};
    w[1] = {3'd2, 11'd11};
    send(w);
    drain();
    m = '0;
    for (int s = 10; s < 14; s++) m[s] = 1'b1;
    chk_map("overlap_direct", sbits, m);
    chk_int("overlap_num", int'(num_clusters), 2);

    // back-pressure: valid held high
    for (int k = 0; k < 8; k++) w[k] = rand_word();
    cl = w;
    clusters_valid = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (clusters_ready) begin
        push_expect(w);
        ready_cycs.push_back(cyc);
      end
      @(negedge clock4x);
    end
    clusters_valid = 1'b0;
    drain();
    chk_int("bp_accepts", ready_cycs.size(), 5);
    for (int i = 1; i < ready_cycs.size(); i++)
      chk_int("bp_interval", ready_cycs[i] - ready_cycs[i-1], 10);

    // reset during EXPAND (edge T+4)
    for (int k = 0; k < 8; k++) w[k] = {3'd3, 11'(100 * k)};
    send(w);
    repeat (3) @(negedge clock4x);
    global_reset = 1'b1;
    @(negedge clock4x);
    global_reset = 1'b0;
    sbq.delete();
    model_err = 0;
    chk_map("rst_sbits", sbits, '0);
    chk_int("rst_ready", int'(clusters_ready), 1);
    chk_int("rst_valid", int'(sbits_valid), 0);
    chk_int("rst_num", int'(num_clusters), 0);
    chk_int("rst_err", int'(err_count), 0);
    repeat (12) @(negedge clock4x);
    send(w);
    drain();
    chk_int("rst_next_num", int'(num_clusters), 8);

    // random sets
    for (int j = 0; j < 40; j++) begin
      for (int k = 0; k < 8; k++) w[k] = rand_word();
      send(w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge clock4x);
    end
    drain();

    // error saturation
    for (int j = 0; j < 300; j++) begin
      for (int k = 0; k < 8; k++) w[k] = {3'($urandom_range(0, 7)), 11'd1600};
      send(w);
    end
    drain();
    chk_int("sat_err", int'(err_count), 255);
    chk_map("sat_sbits", sbits, '0);
    chk_int("sat_num", int'(num_clusters), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
